spi_mcp4822_dac: RTL and testbench

SPI master that drives one channel of an MCP4822 12-bit dual DAC from the 12-bit sample stream of the MCP3202 ADC front end. It sits directly downstream of the ADC SPI master and consumes that block's o_DATA/DATA_VALID pair. On each new sample it shifts one 16-bit command frame (SPI mode 0, MSB first), then pulses LDAC low so the DAC output updates. It runs on the same 125 MHz system clock.

---
 rtl/mcp4822_pkg.sv | 17 +
 rtl/spi_mcp4822_dac.sv | 144 ++++++++++++++
 tb/tb_spi_mcp4822_dac.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/mcp4822_pkg.sv
// mcp4822_pkg: shared state encoding, command layout and frame builder for the MCP4822 DAC master
package mcp4822_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, LS_WAIT, LDAC_PULSE} state_t;
  localparam int CMD_W    = 16;
  localparam int BIT_AB   = 15;
  localparam int BIT_GA   = 13;
  localparam int BIT_SHDN = 12;
  function automatic logic [CMD_W-1:0] mcp4822_cmd(input logic channel, input logic gain, input logic [11:0] data);
    logic [CMD_W-1:0] c;
    c = '0;
    c[BIT_AB] = channel;
    c[BIT_GA] = gain;
    c[BIT_SHDN] = 1'b1;
    c[11:0] = data;
    return c;
  endfunction
endpackage

// File: rtl/spi_mcp4822_dac.sv
// spi_mcp4822_dac: SPI mode-0 master streaming 12-bit samples to one MCP4822 channel, then pulsing LDAC
module spi_mcp4822_dac
  import mcp4822_pkg::*;
#(
  parameter logic CHANNEL  = 1'b0,
  parameter logic GAIN_1X  = 1'b1,
  parameter int   SCK_HALF = 4,
  parameter int   CS_SETUP = 2,
  parameter int   CS_HOLD  = 2,
  parameter int   LS_CYC   = 5,
  parameter int   LDAC_CYC = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] i_DATA,
  input  logic        i_DATA_VALID,
  output logic        MOSI,
  output logic        SCK,
  output logic        CS,
  output logic        LDAC,
  output logic        BUSY,
  output logic        o_OVERRUN
);
  localparam int M0 = SCK_HALF > CS_SETUP ? SCK_HALF : CS_SETUP;
  localparam int M1 = M0 > CS_HOLD ? M0 : CS_HOLD;
  localparam int M2 = M1 > LS_CYC ? M1 : LS_CYC;
  localparam int M3 = M2 > LDAC_CYC ? M2 : LDAC_CYC;
  localparam int CW = $clog2(M3) + 1;
  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [3:0]         idx_q, idx_d;
  logic [CMD_W-1:0]   sr_q, sr_d;
  logic [11:0]        pend_q, pend_d;
  logic               pend_full_q, pend_full_d;
  logic               dv_q, new_s;
  logic               mosi_q, mosi_d, sck_q, sck_d, cs_q, cs_d, ldac_q, ldac_d, busy_q, busy_d, ovr_q, ovr_d;
  assign new_s = i_DATA_VALID & ~dv_q;
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CW'(1);
    idx_d       = idx_q;
    sr_d        = sr_q;
    mosi_d      = mosi_q;
    sck_d       = sck_q;
    cs_d        = cs_q;
    ldac_d      = ldac_q;
    busy_d      = busy_q;
    pend_q_keep: begin end
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    ovr_d       = 1'b0;
    // Outside IDLE a new sample parks in the slot; a second one overwrites it
    if (new_s && state_q != IDLE) begin
      pend_full_d = 1'b1;
      pend_d      = i_DATA;
      ovr_d       = pend_full_q;
    end
    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        idx_d  = '0;
        busy_d = 1'b0;
        if (pend_full_q || new_s) begin
          state_d     = SETUP;
          cs_d        = 1'b0;
          busy_d      = 1'b1;
          sr_d        = mcp4822_cmd(CHANNEL, GAIN_1X, pend_full_q ? pend_q : i_DATA);
          pend_full_d = pend_full_q & new_s;
          pend_d      = new_s ? i_DATA : pend_q;
        end
      end
      SETUP: if (cnt_q == CW'(CS_SETUP - 1)) begin
        state_d = SHIFT;
        cnt_d   = '0;
        mosi_d  = sr_q[CMD_W-1];
      end
      SHIFT: if (cnt_q == CW'(SCK_HALF - 1)) begin
        cnt_d = '0;
        sck_d = ~sck_q;
        if (sck_q) begin
          state_d = idx_q == 4'd15 ? HOLD : SHIFT;
          idx_d   = idx_q == 4'd15 ? 4'd0 : idx_q + 4'd1;
          sr_d    = {sr_q[CMD_W-2:0], 1'b0};
          mosi_d  = idx_q == 4'd15 ? mosi_q : sr_q[CMD_W-2];
        end
      end
      HOLD: if (cnt_q == CW'(CS_HOLD - 1)) begin
        state_d = LS_WAIT;
        cnt_d   = '0;
        cs_d    = 1'b1;
        mosi_d  = 1'b0;
      end
      LS_WAIT: if (cnt_q == CW'(LS_CYC - 1)) begin
        state_d = LDAC_PULSE;
        cnt_d   = '0;
        ldac_d  = 1'b0;
      end
      LDAC_PULSE: if (cnt_q == CW'(LDAC_CYC - 1)) begin
        state_d = IDLE;
        cnt_d   = '0;
        ldac_d  = 1'b1;
        busy_d  = pend_full_d;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      sr_q        <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      dv_q        <= 1'b0;
      mosi_q      <= 1'b0;
      sck_q       <= 1'b0;
      cs_q        <= 1'b1;
      ldac_q      <= 1'b1;
      busy_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      sr_q        <= sr_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      dv_q        <= i_DATA_VALID;
      mosi_q      <= mosi_d;
      sck_q       <= sck_d;
      cs_q        <= cs_d;
      ldac_q      <= ldac_d;
      busy_q      <= busy_d;
      ovr_q       <= ovr_d;
    end
  end
  assign MOSI      = mosi_q;
  assign SCK       = sck_q;
  assign CS        = cs_q;
  assign LDAC      = ldac_q;
  assign BUSY      = busy_q;
  assign o_OVERRUN = ovr_q;
endmodule

// File: tb/tb_spi_mcp4822_dac.sv
// tb_spi_mcp4822_dac: randomized bench comparing the DAC master against a frame-timeline model every cycle
module tb_spi_mcp4822_dac;
  logic clk = 1'b0, rst = 1'b1, dv = 1'b0;
  logic [11:0] din = 12'h000;
  logic mosi, sck, cs, ldac, busy, ovr;
  logic mosi2, sck2, cs2, ldac2, busy2, ovr2;
  always #4 clk = ~clk;
  spi_mcp4822_dac dut (
    .clk(clk), .rst(rst), .i_DATA(din), .i_DATA_VALID(dv),
    .MOSI(mosi), .SCK(sck), .CS(cs), .LDAC(ldac), .BUSY(busy), .o_OVERRUN(ovr)
  );
  spi_mcp4822_dac #(.CHANNEL(1'b1), .GAIN_1X(1'b0)) dut_b (
    .clk(clk), .rst(rst), .i_DATA(din), .i_DATA_VALID(dv),
    .MOSI(mosi2), .SCK(sck2), .CS(cs2), .LDAC(ldac2), .BUSY(busy2), .o_OVERRUN(ovr2)
  );
  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Model: a frame occupies edges s..s+150 relative to its start edge s; everything else follows from k = n - s
  int n = 0, m_s = -1000000;
  logic m_dvp = 1'b0, m_pend = 1'b0, e_ovr = 1'b0, nw, free;
  logic [11:0] m_pend_d = 12'h000, m_data = 12'h000;
  always @(posedge clk) begin
    n++;
    if (rst) begin
      m_s = -1000000; m_pend = 1'b0; m_dvp = 1'b0; e_ovr = 1'b0;
    end else begin
      nw = dv && !m_dvp;
      m_dvp = dv;
      e_ovr = 1'b0;
      free = n > m_s + 150;
      if (free && (m_pend || nw)) begin
        m_data = m_pend ? m_pend_d : din;
        m_s = n;
        if (m_pend && nw) m_pend_d = din;
        m_pend = m_pend && nw;
      end else if (nw) begin
        e_ovr = m_pend;
        m_pend = 1'b1;
        m_pend_d = din;
      end
    end
  end
  always @(negedge clk) if (n > 0) begin : cmp
    int k, j;
    logic [15:0] w;
    logic e_cs, e_sck, e_mosi, e_ldac, e_busy;
    k = n - m_s;
    w = 16'h3000 | {4'h0, m_data};
    j = (k - 2) / 8;
    if (j > 15) j = 15;
    e_cs   = !(k >= 0 && k < 132);
    e_sck  = (k >= 2 && k < 130) && ((k - 2) % 8) >= 4;
    e_mosi = 1'b0;
    if (k >= 2 && k < 132) e_mosi = w[15-j];
    e_ldac = !(k >= 137 && k < 150);
    e_busy = (k >= 0 && k < 150) || (k == 150 && m_pend);
    chk("cs", cs, e_cs);
    chk("sck", sck, e_sck);
    chk("mosi", mosi, e_mosi);
    chk("ldac", ldac, e_ldac);
    chk("busy", busy, e_busy);
    chk("overrun", ovr, e_ovr);
  end
  logic csp = 1'b1, sckp = 1'b0, ldacp = 1'b1, busyp = 1'b0, cs2p = 1'b1, sck2p = 1'b0, gap_on = 1'b0;
  int cs_cnt = 0, cs_len = 0, ldac_cnt = 0, ldac_len = 0, busy_cnt = 0, busy_len = 0;
  int gap_cnt = 0, gap_len = 0, ldac_pulses = 0, ovr_pulses = 0, nbits = 0, nbits2 = 0;
  logic [15:0] sh = 16'h0, sh2 = 16'h0, w2_last = 16'h0;
  logic [15:0] words[$];
  always @(negedge clk) begin
    if (csp && !cs) begin cs_cnt = 0; nbits = 0; gap_on = 1'b0; end
    if (!cs) cs_cnt++;
    if (!csp && cs) begin
      cs_len = cs_cnt;
      if (nbits == 16) words.push_back(sh);
      gap_on = 1'b1;
      gap_cnt = 0;
    end
    if (sck && !sckp) begin sh = {sh[14:0], mosi}; nbits++; end
    if (gap_on && cs && ldac) gap_cnt++;
    if (ldacp && !ldac) begin gap_len = gap_cnt; gap_on = 1'b0; ldac_pulses++; ldac_cnt = 0; end
    if (!ldac) ldac_cnt++;
    if (!ldacp && ldac) ldac_len = ldac_cnt;
    if (!busyp && busy) busy_cnt = 0;
    if (busy) busy_cnt++;
    if (busyp && !busy) busy_len = busy_cnt;
    if (ovr) ovr_pulses++;
    if (cs2p && !cs2) nbits2 = 0;
    if (sck2 && !sck2p) begin sh2 = {sh2[14:0], mosi2}; nbits2++; end
    if (!cs2p && cs2 && nbits2 == 16) begin
      w2_last = sh2;
      chk("dac_b_frame", sh2, 16'h9000 | {4'h0, m_data});
    end
    csp = cs; sckp = sck; ldacp = ldac; busyp = busy; cs2p = cs2; sck2p = sck2;
  end
  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask
  task automatic sample(input logic [11:0] d, input int hold);
    din = d;
    dv = 1'b1;
    cyc(hold);
    dv = 1'b0;
    cyc(1);
  endtask
  initial begin : stim
    int lp, wc, op, hits;
    cyc(3);
    chk("rst_cs", cs, 1'b1);
    chk("rst_sck", sck, 1'b0);
    chk("rst_ldac", ldac, 1'b1);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    cyc(2);
    sample(12'hABC, 1);
    cyc(200);
    chk("t1_frames", words.size(), 1);
    chk("t1_word", words[words.size()-1], 16'h3ABC);
    chk("t1_cs_len", cs_len, 132);
    chk("t1_ldac_len", ldac_len, 13);
    chk("t1_ls_gap", gap_len, 5);
    chk("t1_busy_len", busy_len, 150);
    lp = ldac_pulses;
    sample(12'h5A5, 400);
    cyc(200);
    chk("t2_one_ldac", ldac_pulses, lp + 1);
    chk("t2_word", words[words.size()-1], 16'h35A5);
    op = ovr_pulses;
    sample(12'h456, 1);
    cyc(20);
    sample(12'h123, 1);
    cyc(400);
    chk("t3_first", words[words.size()-2], 16'h3456);
    chk("t3_second", words[words.size()-1], 16'h3123);
    chk("t3_no_overrun", ovr_pulses, op);
    sample(12'h777, 1);
    cyc(10);
    sample(12'h111, 1);
    cyc(10);
    sample(12'h222, 1);
    cyc(400);
    chk("t4_first", words[words.size()-2], 16'h3777);
    chk("t4_newest", words[words.size()-1], 16'h3222);
    chk("t4_overrun_once", ovr_pulses, op + 1);
    hits = 0;
    foreach (words[i]) if (words[i] == 16'h3111) hits++;
    chk("t4_dropped_never_sent", hits, 0);
    lp = ldac_pulses;
    wc = words.size();
    sample(12'h3C3, 1);
    cyc(58);
    chk("t5_mid_frame_cs", cs, 1'b0);
    rst = 1'b1;
    cyc(1);
    chk("t5_rst_cs", cs, 1'b1);
    chk("t5_rst_sck", sck, 1'b0);
    chk("t5_rst_ldac", ldac, 1'b1);
    chk("t5_rst_busy", busy, 1'b0);
    rst = 1'b0;
    cyc(300);
    chk("t5_no_ldac", ldac_pulses, lp);
    chk("t5_no_word", words.size(), wc);
    sample(12'h5A5, 1);
    cyc(200);
    chk("t5_clean_word", words[words.size()-1], 16'h35A5);
    chk("t5_clean_ldac", ldac_pulses, lp + 1);
    sample(12'h000, 1);
    cyc(200);
    chk("t6_dac_b_word", w2_last, 16'h9000);
    chk("t6_dac_a_word", words[words.size()-1], 16'h3000);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) begin rst = 1'b1; cyc(1); rst = 1'b0; end
      sample(12'($urandom_range(0, 4095)), int'($urandom_range(1, 6)));
      cyc(int'($urandom_range(1, 300)));
    end
    cyc(400);
    lp = ldac_pulses;
    repeat (4) begin
      sample(12'($urandom_range(0, 4095)), 1);
      cyc(2498);
    end
    chk("t6_periodic_frames", ldac_pulses, lp + 4);
    cyc(10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
